// File: rtl/write_fifo2region_if.sv
// Bus bundle for write_fifo2region: properties read port, source FIFO read port, region write port.
// Handshake rules: props_re is a one-cycle request answered later by exactly one props_rvalid pulse
// carrying props_rdata; src_re pops one line and src_rvalid/src_rdata return it on the next cycle;
// region_we is an unconditional strobe, and region_almostfull only throttles future src_re.
interface write_fifo2region_if #(
  parameter int WIDTH      = 512,
  parameter int ADDR_WIDTH = 14
);
  logic                  props_re;
  logic [ADDR_WIDTH-1:0] props_raddr;
  logic [1:0]            props_rfifobram;
  logic                  props_rvalid;
  logic [WIDTH-1:0]      props_rdata;
  logic                  src_empty;
  logic                  src_re;
  logic                  src_rvalid;
  logic [WIDTH-1:0]      src_rdata;
  logic                  region_almostfull;
  logic                  region_we;
  logic [ADDR_WIDTH-1:0] region_waddr;
  logic [WIDTH-1:0]      region_wdata;
  logic [1:0]            region_wfifobram;

  modport master (
    output props_re, props_raddr, props_rfifobram, src_re,
           region_we, region_waddr, region_wdata, region_wfifobram,
    input  props_rvalid, props_rdata, src_empty, src_rvalid, src_rdata, region_almostfull
  );

  modport slave (
    input  props_re, props_raddr, props_rfifobram, src_re,
           region_we, region_waddr, region_wdata, region_wfifobram,
    output props_rvalid, props_rdata, src_empty, src_rvalid, src_rdata, region_almostfull
  );
endinterface

// File: rtl/write_fifo2region.sv
// Drains source FIFO lines into a region for a number of iterations; per-iteration base/length
// come either from the config word or from 32-bit slots of a buffered properties line.
module write_fifo2region #(
  parameter int WIDTH      = 512,
  parameter int ADDR_WIDTH = 14
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                op_start,
  output logic                op_done,
  input  logic [31:0]         configreg,
  input  logic [15:0]         iterations,
  write_fifo2region_if.master bus,
  output logic [2:0]          dbg_state
);
  typedef enum logic [2:0] {
    IDLE          = 3'd0,
    FETCH_PROPS   = 3'd1,
    RECEIVE_PROPS = 3'd2,
    MAIN          = 3'd3,
    DRAIN         = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [31:0]           cfg;
  logic [15:0]           iters, iter, req, wr;
  logic [ADDR_WIDTH-1:0] cur_offset;
  logic [WIDTH-1:0]      props_line;
  logic                  we_q, done_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [WIDTH-1:0]      wdata_q;

  logic                  use_props, keep_count;
  logic [13:0]           cfg_len;
  logic [15:0]           iter_nxt, len;
  logic [ADDR_WIDTH-1:0] idx, base;
  logic [3:0]            idx_nxt_lo;
  logic [8:0]            slot_lsb;
  logic [13:0]           slot_base, slot_len;
  logic                  rd_fire, capture, iter_end, last_iter;

  assign use_props  = cfg[14];
  assign keep_count = cfg[15];
  assign cfg_len    = cfg[29:16];
  assign iter_nxt   = iter + 16'd1;
  assign last_iter  = (iter_nxt == iters);

  // Property entry index for the current and the following iteration.
  assign idx        = ADDR_WIDTH'(cfg[13:0]) + ADDR_WIDTH'(iter);
  assign idx_nxt_lo = cfg[3:0] + iter_nxt[3:0];

  assign slot_lsb  = {idx[3:0], 5'd0};
  assign slot_base = props_line[slot_lsb +: 14];
  assign slot_len  = props_line[slot_lsb + 9'd16 +: 14];

  assign base = use_props ? ADDR_WIDTH'(slot_base) : cur_offset;
  assign len  = use_props ? {2'b00, slot_len} : {2'b00, cfg_len};

  assign rd_fire  = (state == MAIN) && (req < len) && !bus.src_empty && !bus.region_almostfull;
  assign capture  = bus.src_rvalid && ((state == MAIN) || (state == DRAIN));
  assign iter_end = (state == DRAIN) && (wr == len);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (op_start && (iterations != 16'd0))
          state_nxt = configreg[14] ? FETCH_PROPS : MAIN;
      end
      FETCH_PROPS:   state_nxt = RECEIVE_PROPS;
      RECEIVE_PROPS: if (bus.props_rvalid) state_nxt = MAIN;
      MAIN:          if (req == len) state_nxt = DRAIN;
      DRAIN: begin
        if (wr == len) begin
          if (last_iter)                              state_nxt = IDLE;
          else if (use_props && (idx_nxt_lo == 4'd0)) state_nxt = FETCH_PROPS;
          else                                        state_nxt = MAIN;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cfg        <= '0;
      iters      <= '0;
      iter       <= '0;
      req        <= '0;
      wr         <= '0;
      cur_offset <= '0;
      props_line <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      we_q   <= capture;
      if ((state == IDLE) && op_start) begin
        cfg        <= configreg;
        iters      <= iterations;
        iter       <= '0;
        req        <= '0;
        wr         <= '0;
        cur_offset <= ADDR_WIDTH'(configreg[13:0]);
        done_q     <= (iterations == 16'd0);
      end
      if ((state == RECEIVE_PROPS) && bus.props_rvalid) props_line <= bus.props_rdata;
      if (rd_fire) req <= req + 16'd1;
      // The write address is fixed at capture time, so a write landing after the iteration ends still uses its own base.
      if (capture) begin
        wr      <= wr + 16'd1;
        waddr_q <= base + ADDR_WIDTH'(wr);
        wdata_q <= bus.src_rdata;
      end
      if (iter_end) begin
        iter <= iter_nxt;
        req  <= '0;
        wr   <= '0;
        if (!use_props && keep_count) cur_offset <= cur_offset + ADDR_WIDTH'(cfg_len);
        if (last_iter) done_q <= 1'b1;
      end
    end
  end

  assign bus.props_re         = (state == FETCH_PROPS);
  assign bus.props_raddr      = (state == FETCH_PROPS) ? (idx >> 4) : '0;
  assign bus.props_rfifobram  = (state == FETCH_PROPS) ? 2'b01 : 2'b00;
  assign bus.src_re           = rd_fire;
  assign bus.region_we        = we_q;
  assign bus.region_waddr     = waddr_q;
  assign bus.region_wdata     = wdata_q;
  assign bus.region_wfifobram = {cfg[31], cfg[30]};
  assign op_done              = done_q;
  assign dbg_state            = state;
endmodule
